sram_8_8192_fi: RTL
===================

Name: sram_8_8192_fi

Overview:
- Cycle-accurate behavioural responder for the 8-bit x 8192-word single-port SRAM that the BIST controller drives.
- Accepts addr/wdata/wen/csn from the BIST mux outputs and returns read data with 1-cycle latency into the BIST compare input.
- Adds a programmable fault-injection engine (stuck-at-0, stuck-at-1, coupling) so the bench can prove that b_fail asserts when it should.
- Keeps saturating access statistics and a sticky fault-hit flag.

Parameters:
- AW, 13, address width (depth = 2**AW = 8192)
- DW, 8, data width
- CW, 16, statistics counter width

Ports:
- b_clk  input  1  clock; all state updates on the rising edge
- b_rst_n  input  1  reset; asynchronous, active-low
- addr  input  AW  word address
- wdata  input  DW  write data
- wen  input  1  0 = write, 1 = read
- csn  input  1  chip select, active-low
- rdata  output  DW  registered read data
- fi_en  input  1  fault injection enable
- fi_mode  input  2  00 none; 01 stuck-at-0; 10 stuck-at-1; 11 coupling
- fi_addr  input  AW  faulty (victim or aggressor) address
- fi_bit  input  3  faulty bit index
- stat_clr  input  1  synchronous clear of counters and fi_hit
- wr_cnt  output  CW  write accesses, saturating
- rd_cnt  output  CW  read accesses, saturating
- fi_hit  output  1  sticky; set when a fault altered stored or returned data

Behaviour:
- Reset: rdata=0, wr_cnt=0, rd_cnt=0, fi_hit=0. The memory array is not reset; contents are undefined until written.
- Access is taken only when csn=0 at the rising edge. When csn=1, nothing changes: no memory update, rdata holds, counters hold.
- Write (csn=0, wen=0): mem[addr] <= wdata at the edge. rdata holds its previous value (no write-through). wr_cnt increments.
- Read (csn=0, wen=1): rdata <= f(mem[addr]) at the edge. Data for the address presented in cycle N is therefore valid throughout cycle N+1, which is where the BIST samples it. rd_cnt increments.
- Counters saturate at 2**CW-1.
- stat_clr=1 zeroes wr_cnt, rd_cnt and fi_hit at the edge, with priority over any increment in the same cycle. Memory and rdata are unaffected.
- Fault functions apply only when fi_en=1. Configuration is sampled every edge, so a change takes effect on the next access; no pipeline.
- fi_mode 01, read of fi_addr: bit fi_bit of the returned data is forced to 0. The stored word is unchanged.
- fi_mode 10, read of fi_addr: bit fi_bit of the returned data is forced to 1. The stored word is unchanged.
- fi_hit (modes 01/10) sets only if the forced bit differs from the stored bit.
- fi_mode 11, write to aggressor fi_addr: the write completes normally, and in the same edge bit fi_bit of the victim mem[fi_addr ^ 1] is inverted. This needs a second internal write port or a read-modify-write on a separate victim register file entry.
- fi_hit (mode 11) sets on every coupling event.
- Coupling victim wrap: fi_addr 0x1FFF couples to 0x1FFE, fi_addr 0x0000 couples to 0x0001.
- fi_mode 00 or fi_en=0: the memory is ideal, and fi_hit can only hold or be cleared.
- Addresses 0x0000 and 0x1FFF are ordinary words; there is no wrap logic beyond plain AW-bit indexing.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous). The array keeps its prior contents, which the bench may rely on only after rewriting them.
- Back-to-back reads at consecutive addresses return one word per cycle with no bubbles.
- Read-after-write to the same address in consecutive cycles returns the newly written data.

Test Plan:
- Fill then read back: write 0x00 to 0x0000..0x1FFF, then read incrementing -> rdata=0x00 every cycle one cycle after each address; wr_cnt=8192, rd_cnt=8192, fi_hit=0.
- Latency check: write 0xA5 @0x0123 then read 0x0123 in the next cycle -> rdata=0xA5 in the following cycle. Then hold csn=1 for 3 cycles -> rdata stays 0xA5 and counters are unchanged.
- Stuck-at-1: fi_en=1, mode=10, fi_addr=0x0800, fi_bit=3; write 0x00 @0x0800 and read it -> rdata=0x08, fi_hit=1. Read 0x0801 -> unaffected.
- Coupling with wrap: mode=11, fi_addr=0x1FFF, fi_bit=7; preload 0x1FFE=0xFF, write 0x00 @0x1FFF, read 0x1FFE -> rdata=0x7F, fi_hit=1.
- Full BIST loop: connect to the BIST controller. With fi_en=0 -> b_done=1, b_fail=0. With mode=01, fi_addr=0x1000, fi_bit=0 -> b_fail=1 during the 0xFF compare phase.
- Saturation and clear: force 65540 reads -> rd_cnt=0xFFFF. Assert stat_clr together with a read -> rd_cnt=0 and fi_hit=0 next cycle. Async reset mid-read -> rdata=0 immediately.

Source files
------------

// File: rtl/sram_8_8192_fi.sv
// Behavioural single-port SRAM for the BIST path: 1-cycle registered read, with fault injection
// (stuck-at on the read path, coupling on write) and saturating access statistics.
module sram_8_8192_fi #(
  parameter int AW = 13,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          b_clk,
  input  logic          b_rst_n,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          wen,
  input  logic          csn,
  output logic [DW-1:0] rdata,
  input  logic          fi_en,
  input  logic [1:0]    fi_mode,
  input  logic [AW-1:0] fi_addr,
  input  logic [2:0]    fi_bit,
  input  logic          stat_clr,
  output logic [CW-1:0] wr_cnt,
  output logic [CW-1:0] rd_cnt,
  output logic          fi_hit
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  logic          acc_wr;
  logic          acc_rd;
  logic          fi_match;
  logic          couple;
  logic          force_hit;
  logic [AW-1:0] victim;
  logic [DW-1:0] stored;
  logic [DW-1:0] bit_mask;
  logic [DW-1:0] rd_val;

  assign acc_wr   = !csn && !wen;
  assign acc_rd   = !csn && wen;
  assign fi_match = fi_en && (addr == fi_addr);
  assign couple   = acc_wr && fi_match && (fi_mode == 2'b11);
  // Victim is the pair partner of the aggressor, so 0x1FFF hits 0x1FFE and 0x0000 hits 0x0001.
  assign victim   = fi_addr ^ AW'(1);
  assign stored   = mem[addr];
  assign bit_mask = DW'(1) << fi_bit;

  always_comb begin
    rd_val = stored;
    if (fi_match && fi_mode == 2'b01) begin
      rd_val = stored & ~bit_mask;
    end else if (fi_match && fi_mode == 2'b10) begin
      rd_val = stored | bit_mask;
    end
  end

  assign force_hit = acc_rd && (rd_val != stored);

  // Array is intentionally not reset; victim never equals the aggressor so both writes are disjoint.
  always_ff @(posedge b_clk) begin
    if (acc_wr) begin
      mem[addr] <= wdata;
    end
    if (couple) begin
      mem[victim][fi_bit] <= ~mem[victim][fi_bit];
    end
  end

  always_ff @(posedge b_clk or negedge b_rst_n) begin
    if (!b_rst_n) begin
      rdata <= '0;
    end else if (acc_rd) begin
      rdata <= rd_val;
    end
  end

  always_ff @(posedge b_clk or negedge b_rst_n) begin
    if (!b_rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      fi_hit <= 1'b0;
    end else if (stat_clr) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      fi_hit <= 1'b0;
    end else begin
      if (acc_wr && wr_cnt != '1) begin
        wr_cnt <= wr_cnt + CW'(1);
      end
      if (acc_rd && rd_cnt != '1) begin
        rd_cnt <= rd_cnt + CW'(1);
      end
      if (force_hit || couple) begin
        fi_hit <= 1'b1;
      end
    end
  end

endmodule
